// File: rtl/acc.sv
// Partial-sum accumulator: one FIFO per systolic-array column that preloads psums, then
// accumulates in place once full; finished sums drain through a registered read port.
`timescale 1ns/1ps
module acc #(
  parameter int unsigned PE_SIZE    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PE_SIZE-1:0]            psum_en_i,
  input  logic [PE_SIZE-1:0]            rden_i,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] psum_row_i,
  output logic [DATA_WIDTH*PE_SIZE-1:0] psum_row_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  for (genvar c = 0; c < PE_SIZE; c++) begin : g_col
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wptr_q;
    logic [PtrW-1:0]       rptr_q;
    logic [CntW-1:0]       count_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] psum;
    logic [DATA_WIDTH-1:0] head;
    logic                  full;
    logic                  empty;

    assign psum  = psum_row_i[DATA_WIDTH*c +: DATA_WIDTH];
    assign head  = mem_q[rptr_q];
    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          mem_q[i] <= '0;
        end
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        rd_q    <= '0;
      end else if (psum_en_i[c]) begin
        // When full, wptr == rptr: the head is popped and its sum lands at the tail.
        if (full) begin
          mem_q[wptr_q] <= head + psum;
          rptr_q        <= rptr_q + PtrOne;
        end else begin
          mem_q[wptr_q] <= psum;
          count_q       <= count_q + CntOne;
        end
        wptr_q <= wptr_q + PtrOne;
      end else if (rden_i[c] && !empty) begin
        rd_q    <= head;
        rptr_q  <= rptr_q + PtrOne;
        count_q <= count_q - CntOne;
      end
    end

    assign psum_row_o[DATA_WIDTH*c +: DATA_WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_acc.sv
// Scoreboard bench for acc: read cycles push expected rows, a monitor compares after each read.
`timescale 1ns/1ps
module tb_acc;

  localparam int PE = 4;
  localparam int DW = 32;

  logic               clk;
  logic               rst_n;
  logic [PE-1:0]      psum_en;
  logic [PE-1:0]      rden;
  logic [DW*PE-1:0]   psum_row;
  logic [DW*PE-1:0]   row_out;

  int checks = 0;
  int errors = 0;

  logic [DW*PE-1:0] exp_q [$];
  string            name_q [$];
  logic [DW*PE-1:0] mon_exp;
  string            mon_name;

  acc #(
    .PE_SIZE   (PE),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psum_en_i (psum_en),
    .rden_i    (rden),
    .psum_row_i(psum_row),
    .psum_row_o(row_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  function automatic logic [DW*PE-1:0] mkrow(input logic [DW-1:0] c3, input logic [DW-1:0] c2,
                                             input logic [DW-1:0] c1, input logic [DW-1:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  // Monitor: any read-enable cycle produces an output to compare one edge later.
  always @(posedge clk) begin
    if (rst_n && rden != '0) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expect: got %h want (no queued expectation)", row_out);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (row_out !== mon_exp) begin
          errors++;
          $display("FAIL %s: got %h want %h", mon_name, row_out, mon_exp);
        end
      end
    end
  end

  task automatic cyc(input logic [PE-1:0] en, input logic [PE-1:0] rd, input logic [DW*PE-1:0] row);
    @(negedge clk);
    psum_en  = en;
    rden     = rd;
    psum_row = row;
  endtask

  task automatic rdx(input logic [PE-1:0] en, input logic [PE-1:0] rd, input logic [DW*PE-1:0] row,
                     input logic [DW*PE-1:0] exp, input string nm);
    cyc(en, rd, row);
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    psum_en = '0;
    rden    = '0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
  endtask

  task automatic preload4();
    cyc(4'b1111, 4'b0000, mkrow(1, 2, 3, 4));
    cyc(4'b1111, 4'b0000, mkrow(2, 3, 4, 5));
    cyc(4'b1111, 4'b0000, mkrow(3, 4, 5, 6));
    cyc(4'b1111, 4'b0000, mkrow(4, 5, 6, 7));
  endtask

  logic [DW-1:0]    v;
  logic [DW*PE-1:0] acc_row;

  initial begin
    rst_n    = 1'b0;
    psum_en  = '0;
    rden     = '0;
    psum_row = '0;
    #2;
    checks++;
    if (row_out !== '0) begin
      errors++;
      $display("FAIL reset_init: got %h want 0", row_out);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Preload then drain: oldest row first.
    preload4();
    rdx(4'b0000, 4'b1111, '0, mkrow(1, 2, 3, 4), "preload_rd0");
    rdx(4'b0000, 4'b1111, '0, mkrow(2, 3, 4, 5), "preload_rd1");
    rdx(4'b0000, 4'b1111, '0, mkrow(3, 4, 5, 6), "preload_rd2");
    rdx(4'b0000, 4'b1111, '0, mkrow(4, 5, 6, 7), "preload_rd3");

    // Mid-cycle reset clears the output register immediately.
    cyc(4'b0000, 4'b0000, '0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (row_out !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h want 0", row_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdx(4'b0000, 4'b1111, '0, '0, "empty_rd");

    // Accumulate: three rounds of 0x10/0x100/0x1000/0x10000 over a fresh preload.
    do_reset();
    preload4();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        v = 32'h10 << (4 * k);
        cyc(4'b1111, 4'b0000, mkrow(v, v, v, v));
      end
    end
    for (int k = 0; k < 4; k++) begin
      v = 32'h10 << (4 * k);
      for (int c = 0; c < PE; c++) acc_row[DW*c +: DW] = DW'(k + 4 - c) + 3 * v;
      rdx(4'b0000, 4'b1111, '0, acc_row, $sformatf("accum_rd%0d", k));
    end
    rdx(4'b0000, 4'b1111, '0, mkrow(32'h30004, 32'h30005, 32'h30006, 32'h30007), "over_read");

    // Wrap-around on col0 with per-column enables; col1 holds one untouched word.
    do_reset();
    cyc(4'b0010, 4'b0000, mkrow(32'h11, 32'h22, 32'hAA, 32'h33));
    repeat (4) cyc(4'b0001, 4'b0000, mkrow(32'h55, 32'h55, 32'h55, 32'hFFFF_FFFF));
    repeat (4) cyc(4'b0001, 4'b0000, mkrow(32'h77, 32'h77, 32'h77, 32'h2));
    rdx(4'b0000, 4'b1111, '0, mkrow(0, 0, 32'hAA, 1), "wrap_rd0");
    rdx(4'b0000, 4'b1111, '0, mkrow(0, 0, 32'hAA, 1), "wrap_rd1");
    rdx(4'b0000, 4'b1111, '0, mkrow(0, 0, 32'hAA, 1), "wrap_rd2");
    rdx(4'b0000, 4'b1111, '0, mkrow(0, 0, 32'hAA, 1), "wrap_rd3");
    rdx(4'b0000, 4'b1111, '0, mkrow(0, 0, 32'hAA, 1), "wrap_hold");

    // Collision on a full col0: accumulate wins, output slice unchanged.
    cyc(4'b0001, 4'b0000, mkrow(0, 0, 0, 1));
    cyc(4'b0001, 4'b0000, mkrow(0, 0, 0, 2));
    cyc(4'b0001, 4'b0000, mkrow(0, 0, 0, 3));
    cyc(4'b0001, 4'b0000, mkrow(0, 0, 0, 4));
    rdx(4'b0001, 4'b0001, mkrow(0, 0, 0, 32'h100), mkrow(0, 0, 32'hAA, 1), "collide");
    rdx(4'b0000, 4'b0001, '0, mkrow(0, 0, 32'hAA, 2), "collide_rd0");
    rdx(4'b0000, 4'b0001, '0, mkrow(0, 0, 32'hAA, 3), "collide_rd1");
    rdx(4'b0000, 4'b0001, '0, mkrow(0, 0, 32'hAA, 4), "collide_rd2");
    rdx(4'b0000, 4'b0001, '0, mkrow(0, 0, 32'hAA, 32'h101), "collide_rd3");

    cyc(4'b0000, 4'b0000, '0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect: got %0d pending want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
